reg_writeback: RTL

REG_WRITEBACK -- requirements
Module: reg_writeback

---
 rtl/reg_writeback.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/reg_writeback.sv
// Register writeback stage: merges single-cycle ALU results with a FIFO of mul/div results and tracks pending registers.
// Define REG_WRITEBACK_BYPASS_EN to forward the registered write onto the R1/R2 bypass outputs.
module reg_writeback #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_wr,
  input  logic [31:0] alu_wd,
  input  logic        md_valid,
  input  logic [4:0]  md_wr,
  input  logic [31:0] md_wd,
  output logic        md_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  R1,
  input  logic [4:0]  R2,
  output logic        stall,
  output logic        Regwrite,
  output logic [4:0]  WR,
  output logic [31:0] WD,
  output logic        fwd1_hit,
  output logic [31:0] fwd1_data,
  output logic        fwd2_hit,
  output logic [31:0] fwd2_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [4:0]       fifo_wr_q [FIFO_DEPTH];
  logic [31:0]      fifo_wd_q [FIFO_DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;

  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic [4:0]  head_wr;
  logic [31:0] head_wd;

  logic        wb_en;
  logic [4:0]  wb_wr;
  logic [31:0] wb_wd;

  logic [31:0] pending_q;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;

  // Ready depends on occupancy alone, so a full FIFO refuses a push even when it pops this edge.
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign md_ready   = !fifo_full;
  assign push       = md_valid && md_ready;
  assign pop        = !alu_valid && !fifo_empty;
  assign head_wr    = fifo_wr_q[head_q];
  assign head_wd    = fifo_wd_q[head_q];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wr_q[tail_q] <= md_wr;
      fifo_wd_q[tail_q] <= md_wd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        tail_q <= tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_q <= head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    wb_en = 1'b0;
    wb_wr = alu_wr;
    wb_wd = alu_wd;
    if (alu_valid) begin
      wb_en = 1'b1;
    end else if (pop) begin
      wb_en = 1'b1;
      wb_wr = head_wr;
      wb_wd = head_wd;
    end
  end

  // A write to r0 is consumed silently; WR/WD keep the last real write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Regwrite <= 1'b0;
      WR       <= '0;
      WD       <= '0;
    end else begin
      Regwrite <= wb_en && (wb_wr != '0);
      if (wb_en && (wb_wr != '0)) begin
        WR <= wb_wr;
        WD <= wb_wd;
      end
    end
  end

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_valid) begin
      set_mask[issue_rd] = 1'b1;
    end
    if (pop) begin
      clr_mask[head_wr] = 1'b1;
    end
    set_mask[0] = 1'b0;
  end

  // Set is applied after clear so a same-edge reissue keeps the register pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= (pending_q & ~clr_mask) | set_mask;
    end
  end

  assign stall = (pending_q[R1] && (R1 != '0)) || (pending_q[R2] && (R2 != '0));

`ifdef REG_WRITEBACK_BYPASS_EN
  assign fwd1_hit  = Regwrite && (WR == R1) && (R1 != '0);
  assign fwd1_data = WD;
  assign fwd2_hit  = Regwrite && (WR == R2) && (R2 != '0);
  assign fwd2_data = WD;
`else
  assign fwd1_hit  = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_hit  = 1'b0;
  assign fwd2_data = '0;
`endif

endmodule
